// File: rtl/audio_ram_arbiter.sv
// Arbitrates the single-port 8K x 16 ADPCM sector buffer RAM between the audio decoder read port
// and the CPU bus port. The decoder has fixed priority; a starvation guard bounds CPU wait.
module audio_ram_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [ADDR_W-1:0]                     dec_addr_i,
  input  logic                                  dec_rd_i,
  output logic [15:0]                           dec_data_o,
  output logic                                  dec_ack_o,
  output logic                                  dec_ack_q_o,
  input  logic [ADDR_W-1:0]                     cpu_addr_i,
  input  logic                                  cpu_rd_i,
  input  logic                                  cpu_wr_i,
  input  logic [1:0]                            cpu_be_i,
  input  logic [15:0]                           cpu_wdata_i,
  output logic [15:0]                           cpu_rdata_o,
  output logic                                  cpu_ack_o,
  output logic [ADDR_W-1:0]                     ram_addr_o,
  output logic [1:0]                            ram_we_o,
  output logic [15:0]                           ram_wdata_o,
  input  logic [15:0]                           ram_rdata_i,
  output logic [1:0]                            dbg_state_o,
  output logic [$clog2(STARVE_LIMIT+1)-1:0]     dbg_starve_o
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_DATA  = 2'd2,
    WR_ISSUE = 2'd3
  } state_t;

  // Handshake: a requester raises its rd/wr level and holds it with a stable address
  // until its ack pulse; the request is ignored during that ack cycle so a master that
  // drops it one cycle late is not served twice.
  state_t              state_q, state_d;
  logic                sel_cpu_q, sel_cpu_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [1:0]          ram_we_q, ram_we_d;
  logic [15:0]         ram_wdata_q, ram_wdata_d;
  logic [15:0]         dec_data_q, dec_data_d;
  logic [15:0]         cpu_rdata_q, cpu_rdata_d;
  logic                dec_ack_q, dec_ack_d;
  logic                dec_ack_dly_q, dec_ack_dly_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic [SW-1:0]       starve_q, starve_d;

  logic cpu_req;
  logic dec_elig;
  logic cpu_elig;
  logic grant_cpu;
  logic grant_dec;

  assign cpu_req   = cpu_rd_i | cpu_wr_i;
  assign dec_elig  = dec_rd_i & ~dec_ack_q;
  assign cpu_elig  = cpu_req & ~cpu_ack_q;
  assign grant_cpu = (state_q == IDLE) && cpu_elig && ((starve_q == LIMIT) || !dec_elig);
  assign grant_dec = (state_q == IDLE) && dec_elig && !grant_cpu;

  always_comb begin
    state_d       = state_q;
    sel_cpu_d     = sel_cpu_q;
    ram_addr_d    = ram_addr_q;
    ram_we_d      = 2'b00;
    ram_wdata_d   = ram_wdata_q;
    dec_data_d    = dec_data_q;
    cpu_rdata_d   = cpu_rdata_q;
    dec_ack_d     = 1'b0;
    cpu_ack_d     = 1'b0;
    dec_ack_dly_d = dec_ack_q;
    starve_d      = starve_q;

    unique case (state_q)
      IDLE: begin
        if (grant_cpu) begin
          sel_cpu_d   = 1'b1;
          ram_addr_d  = cpu_addr_i;
          ram_wdata_d = cpu_wdata_i;
          starve_d    = '0;
          // A simultaneous rd+wr is treated as a write.
          if (cpu_wr_i) begin
            ram_we_d = cpu_be_i;
            state_d  = WR_ISSUE;
          end else begin
            state_d  = RD_ISSUE;
          end
        end else if (grant_dec) begin
          sel_cpu_d  = 1'b0;
          ram_addr_d = dec_addr_i;
          state_d    = RD_ISSUE;
          if (!cpu_req) begin
            starve_d = '0;
          end else if (starve_q != LIMIT) begin
            starve_d = starve_q + 1'b1;
          end
        end else if (!cpu_req) begin
          starve_d = '0;
        end
      end
      RD_ISSUE: begin
        state_d = RD_DATA;
        if (!cpu_req) starve_d = '0;
      end
      RD_DATA: begin
        state_d = IDLE;
        if (sel_cpu_q) begin
          cpu_rdata_d = ram_rdata_i;
          cpu_ack_d   = 1'b1;
        end else begin
          dec_data_d  = ram_rdata_i;
          dec_ack_d   = 1'b1;
        end
        if (!cpu_req) starve_d = '0;
      end
      WR_ISSUE: begin
        state_d   = IDLE;
        cpu_ack_d = 1'b1;
        if (!cpu_req) starve_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      sel_cpu_q     <= 1'b0;
      ram_addr_q    <= '0;
      ram_we_q      <= 2'b00;
      ram_wdata_q   <= '0;
      dec_data_q    <= '0;
      cpu_rdata_q   <= '0;
      dec_ack_q     <= 1'b0;
      dec_ack_dly_q <= 1'b0;
      cpu_ack_q     <= 1'b0;
      starve_q      <= '0;
    end else begin
      state_q       <= state_d;
      sel_cpu_q     <= sel_cpu_d;
      ram_addr_q    <= ram_addr_d;
      ram_we_q      <= ram_we_d;
      ram_wdata_q   <= ram_wdata_d;
      dec_data_q    <= dec_data_d;
      cpu_rdata_q   <= cpu_rdata_d;
      dec_ack_q     <= dec_ack_d;
      dec_ack_dly_q <= dec_ack_dly_d;
      cpu_ack_q     <= cpu_ack_d;
      starve_q      <= starve_d;
    end
  end

  assign dec_data_o   = dec_data_q;
  assign dec_ack_o    = dec_ack_q;
  assign dec_ack_q_o  = dec_ack_dly_q;
  assign cpu_rdata_o  = cpu_rdata_q;
  assign cpu_ack_o    = cpu_ack_q;
  assign ram_addr_o   = ram_addr_q;
  assign ram_we_o     = ram_we_q;
  assign ram_wdata_o  = ram_wdata_q;
  assign dbg_state_o  = state_q;
  assign dbg_starve_o = starve_q;

endmodule

// File: tb/tb_audio_ram_arbiter.sv
// Directed bench for audio_ram_arbiter with a behavioural 8K x 16 byte-writable RAM and
// expected-data queues popped on each ack pulse.
module tb_audio_ram_arbiter;

  localparam int ADDR_W = 13;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [ADDR_W-1:0] dec_addr = '0;
  logic dec_rd = 1'b0;
  logic [15:0] dec_data;
  logic dec_ack, dec_ack_q;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [1:0] cpu_be = 2'b00;
  logic [15:0] cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic cpu_ack;
  logic [ADDR_W-1:0] ram_addr;
  logic [1:0] ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata = '0;
  logic [1:0] dbg_state;
  logic [2:0] dbg_starve;

  logic [15:0] mem [0:(1<<ADDR_W)-1];
  logic [15:0] dec_q [$];
  logic [15:0] cpu_q [$];
  logic [15:0] last_cpu_rdata = '0;
  logic prev_dec_ack = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  audio_ram_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .dec_addr_i(dec_addr), .dec_rd_i(dec_rd), .dec_data_o(dec_data),
    .dec_ack_o(dec_ack), .dec_ack_q_o(dec_ack_q),
    .cpu_addr_i(cpu_addr), .cpu_rd_i(cpu_rd), .cpu_wr_i(cpu_wr), .cpu_be_i(cpu_be),
    .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .cpu_ack_o(cpu_ack),
    .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_wdata_o(ram_wdata),
    .ram_rdata_i(ram_rdata), .dbg_state_o(dbg_state), .dbg_starve_o(dbg_starve)
  );

  // RAM macro: synchronous read-first, byte write enables.
  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we[0]) mem[ram_addr][7:0]  <= ram_wdata[7:0];
    if (ram_we[1]) mem[ram_addr][15:8] <= ram_wdata[15:8];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; sample #1 after the edge and run the ack scoreboards.
  task automatic tick();
    logic rst_at_edge;
    rst_at_edge = reset;
    @(posedge clk);
    #1;
    cyc++;
    chk("dec_ack_q", {31'd0, dec_ack_q}, rst_at_edge ? 32'd0 : {31'd0, prev_dec_ack});
    prev_dec_ack = dec_ack;
    if (dec_ack) begin
      if (dec_q.size() == 0) chk("dec_spurious_ack", 32'd1, 32'd0);
      else chk("dec_data", {16'd0, dec_data}, {16'd0, dec_q.pop_front()});
    end
    if (cpu_ack) begin
      if (cpu_q.size() == 0) chk("cpu_spurious_ack", 32'd1, 32'd0);
      else chk("cpu_rdata", {16'd0, cpu_rdata}, {16'd0, cpu_q.pop_front()});
    end
  endtask

  task automatic dec_read(input logic [ADDR_W-1:0] a, input logic [15:0] exp, output int lat);
    dec_q.push_back(exp);
    dec_addr = a;
    dec_rd = 1'b1;
    lat = 0;
    do begin tick(); lat++; end while (!dec_ack && lat < 20);
    if (!dec_ack) chk("dec_timeout", 32'd1, 32'd0);
    dec_rd = 1'b0;
  endtask

  task automatic cpu_read(input logic [ADDR_W-1:0] a, input logic [15:0] exp, output int lat);
    cpu_q.push_back(exp);
    last_cpu_rdata = exp;
    cpu_addr = a;
    cpu_rd = 1'b1;
    lat = 0;
    do begin tick(); lat++; end while (!cpu_ack && lat < 20);
    if (!cpu_ack) chk("cpu_rd_timeout", 32'd1, 32'd0);
    cpu_rd = 1'b0;
  endtask

  task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [15:0] d, input logic [1:0] be,
                           input logic also_rd, input logic [15:0] exp_word);
    int lat;
    cpu_q.push_back(last_cpu_rdata);
    cpu_addr = a; cpu_wdata = d; cpu_be = be;
    cpu_wr = 1'b1; cpu_rd = also_rd;
    lat = 0;
    do begin
      tick(); lat++;
      if (lat == 1) chk("wr_we_c1", {30'd0, ram_we}, {30'd0, be});
    end while (!cpu_ack && lat < 20);
    chk("wr_latency", lat, 2);
    chk("wr_we_c2", {30'd0, ram_we}, 32'd0);
    cpu_wr = 1'b0; cpu_rd = 1'b0;
    chk("wr_mem", {16'd0, mem[a]}, {16'd0, exp_word});
  endtask

  initial begin
    int lat, dec_cyc, cpu_cyc, n_before, n_after;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 16'h0000;

    // Reset state
    reset = 1'b1;
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_dec_data", {16'd0, dec_data}, 32'd0);
    chk("rst_cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
    chk("rst_ram_addr", {19'd0, ram_addr}, 32'd0);
    chk("rst_ram_we", {30'd0, ram_we}, 32'd0);
    chk("rst_ram_wdata", {16'd0, ram_wdata}, 32'd0);
    chk("rst_acks", {29'd0, dec_ack, dec_ack_q, cpu_ack}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    chk("rst_starve", {29'd0, dbg_starve}, 32'd0);

    // T1: decoder read, single access
    mem[13'h0010] = 16'hBEEF;
    dec_read(13'h0010, 16'hBEEF, lat);
    chk("t1_latency", lat, 3);
    chk("t1_ram_addr", {19'd0, ram_addr}, 32'h10);
    tick();
    chk("t1_ack_q", {31'd0, dec_ack_q}, 32'd1);
    repeat (5) tick();

    // T2: CPU byte-masked write, rd+wr overlap, be==0, read-back
    mem[13'h1400] = 16'hAAAA;
    cpu_write(13'h1400, 16'h1234, 2'b01, 1'b0, 16'hAA34);
    tick();
    cpu_write(13'h1401, 16'h9900, 2'b10, 1'b1, 16'h9900);
    tick();
    cpu_write(13'h1400, 16'hFFFF, 2'b00, 1'b0, 16'hAA34);
    tick();
    cpu_read(13'h1400, 16'hAA34, lat);
    chk("t2_rd_latency", lat, 3);
    tick();

    // T3: simultaneous requests, decoder first, CPU three cycles later
    mem[13'h0020] = 16'h1111;
    mem[13'h0030] = 16'h2222;
    dec_q.push_back(16'h1111);
    cpu_q.push_back(16'h2222);
    last_cpu_rdata = 16'h2222;
    dec_addr = 13'h0020; cpu_addr = 13'h0030;
    dec_rd = 1'b1; cpu_rd = 1'b1;
    dec_cyc = 0; cpu_cyc = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (dec_ack) begin dec_cyc = c; dec_rd = 1'b0; end
      if (cpu_ack) begin cpu_cyc = c; cpu_rd = 1'b0; end
    end
    dec_rd = 1'b0; cpu_rd = 1'b0;
    chk("t3_dec_cycle", dec_cyc, 3);
    chk("t3_cpu_cycle", cpu_cyc, 6);

    // T4: decoder hammering with a CPU write pending; CPU wait stays bounded
    mem[13'h0040] = 16'h4444;
    mem[13'h1900] = 16'h0000;
    cpu_q.push_back(last_cpu_rdata);
    cpu_addr = 13'h1900; cpu_wdata = 16'h5555; cpu_be = 2'b11; cpu_wr = 1'b1;
    dec_addr = 13'h0040; dec_rd = 1'b1;
    cpu_cyc = 0; n_before = 0; n_after = 0;
    for (int c = 1; c <= 40; c++) begin
      if (dec_q.size() == 0) dec_q.push_back(16'h4444);
      tick();
      if (dec_ack) begin
        if (cpu_cyc == 0) n_before++;
        else n_after++;
      end
      if (cpu_ack) begin cpu_cyc = c; cpu_wr = 1'b0; end
    end
    dec_rd = 1'b0;
    cpu_wr = 1'b0;
    repeat (4) tick();
    dec_q.delete();
    chk("t4_cpu_acked", {31'd0, cpu_cyc != 0}, 32'd1);
    chk("t4_cpu_bound", {31'd0, cpu_cyc <= (STARVE_LIMIT + 1) * 3 + 2}, 32'd1);
    chk("t4_dec_first", {31'd0, n_before >= 1}, 32'd1);
    chk("t4_dec_bound", {31'd0, n_before <= STARVE_LIMIT}, 32'd1);
    chk("t4_dec_resumes", {31'd0, n_after >= 1}, 32'd1);
    chk("t4_mem", {16'd0, mem[13'h1900]}, 32'h5555);

    // T5: reset during RD_DATA abandons the read
    mem[13'h0050] = 16'h5A5A;
    dec_addr = 13'h0050; dec_rd = 1'b1;
    tick(); tick();
    reset = 1'b1; dec_rd = 1'b0;
    tick();
    chk("t5_dec_ack", {31'd0, dec_ack}, 32'd0);
    chk("t5_dec_data", {16'd0, dec_data}, 32'd0);
    chk("t5_cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
    chk("t5_ram_addr", {19'd0, ram_addr}, 32'd0);
    chk("t5_ram_we", {30'd0, ram_we}, 32'd0);
    chk("t5_state", {30'd0, dbg_state}, 32'd0);
    reset = 1'b0;
    last_cpu_rdata = 16'h0000;
    tick();
    dec_read(13'h0050, 16'h5A5A, lat);
    chk("t5_latency", lat, 3);
    tick();

    // T6: cpu_rd held through its ack cycle is not served twice
    cpu_q.push_back(16'hAA34);
    last_cpu_rdata = 16'hAA34;
    cpu_addr = 13'h1400; cpu_rd = 1'b1;
    lat = 0;
    do begin tick(); lat++; end while (!cpu_ack && lat < 20);
    chk("t6_latency", lat, 3);
    tick();
    cpu_rd = 1'b0;
    chk("t6_state", {30'd0, dbg_state}, 32'd0);
    repeat (8) tick();
    chk("t6_queue_empty", cpu_q.size() + dec_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
